// File: rtl/decode_stage.sv
// ID stage: 32x32 register file, immediate extension, load-use hazard detection and ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN forwards a same-cycle writeback to the register reads.
package decode_stage_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned IMM_W  = 16;

  localparam logic [OP_W-1:0] OP_LW   = 6'h23;
  localparam logic [OP_W-1:0] OP_ANDI = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI = 6'h0E;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic            valid;
  } idex_t;
endpackage

module decode_stage
  import decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [XLEN-1:0]   pc_plus4_i,
  input  logic              valid_i,
  input  logic              wb_regwrite_i,
  input  logic [REG_AW-1:0] wb_writereg_i,
  input  logic [XLEN-1:0]   wb_result_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [XLEN-1:0]   instr_o,
  output logic [XLEN-1:0]   pc_plus4_o,
  output logic [XLEN-1:0]   rd1_o,
  output logic [XLEN-1:0]   rd2_o,
  output logic [XLEN-1:0]   imm_o,
  output logic              valid_o,
  output logic              stall_req_o
);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic                       wb_wen;
  logic [REG_AW-1:0]          rs;
  logic [REG_AW-1:0]          rt;
  logic [OP_W-1:0]            opcode;
  logic [XLEN-1:0]            rd1;
  logic [XLEN-1:0]            rd2;
  logic [XLEN-1:0]            imm;
  logic                       zero_ext;
  logic                       load_use;
  idex_t                      idex_q;
  idex_t                      idex_load;

  assign wb_wen = wb_regwrite_i && (wb_writereg_i != '0);
  assign rs     = instr_i[25:21];
  assign rt     = instr_i[20:16];
  assign opcode = instr_i[31:26];

  // Register file; entry 0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else if (wb_wen) begin
      regs[wb_writereg_i] <= wb_result_i;
    end
  end

  always_comb begin
    rd1 = regs[rs];
    rd2 = regs[rt];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_wen && (wb_writereg_i == rs)) rd1 = wb_result_i;
    if (wb_wen && (wb_writereg_i == rt)) rd2 = wb_result_i;
`endif
    if (rs == '0) rd1 = '0;
    if (rt == '0) rd2 = '0;
  end

  // Logical immediates are zero-extended, everything else sign-extended.
  always_comb begin
    zero_ext = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
    if (zero_ext) imm = {{(XLEN-IMM_W){1'b0}}, instr_i[15:0]};
    else          imm = {{(XLEN-IMM_W){instr_i[15]}}, instr_i[15:0]};
  end

  // Load in EX whose destination is a source of the instruction now in ID.
  always_comb begin
    load_use = idex_q.valid
            && (idex_q.instr[31:26] == OP_LW)
            && (idex_q.instr[20:16] != '0)
            && valid_i
            && ((idex_q.instr[20:16] == rs) || (idex_q.instr[20:16] == rt));
  end

  assign stall_req_o = load_use;

  always_comb begin
    idex_load          = '0;
    idex_load.instr    = instr_i;
    idex_load.pc_plus4 = pc_plus4_i;
    idex_load.rd1      = rd1;
    idex_load.rd2      = rd2;
    idex_load.imm      = imm;
    idex_load.valid    = valid_i;
  end

  // ID/EX register: reset > flush > external stall > load-use bubble > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q <= '0;
    end else if (flush_i) begin
      idex_q <= '0;
    end else if (stall_i) begin
      idex_q <= idex_q;
    end else if (load_use) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_load;
    end
  end

  assign instr_o    = idex_q.instr;
  assign pc_plus4_o = idex_q.pc_plus4;
  assign rd1_o      = idex_q.rd1;
  assign rd2_o      = idex_q.rd2;
  assign imm_o      = idex_q.imm;
  assign valid_o    = idex_q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic, all checked against a behavioural model.
// Honours DECODE_WB_BYPASS_EN when the same macro is given to the build.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instr_i;
  logic [31:0] pc_plus4_i;
  logic        valid_i;
  logic        wb_regwrite_i;
  logic [4:0]  wb_writereg_i;
  logic [31:0] wb_result_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] rd1_o;
  logic [31:0] rd2_o;
  logic [31:0] imm_o;
  logic        valid_o;
  logic        stall_req_o;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_instr, m_pc, m_rd1, m_rd2, m_imm;
  logic        m_valid;

  decode_stage dut (
    .clk(clk), .reset(reset), .instr_i(instr_i), .pc_plus4_i(pc_plus4_i),
    .valid_i(valid_i), .wb_regwrite_i(wb_regwrite_i), .wb_writereg_i(wb_writereg_i),
    .wb_result_i(wb_result_i), .stall_i(stall_i), .flush_i(flush_i),
    .instr_o(instr_o), .pc_plus4_o(pc_plus4_o), .rd1_o(rd1_o), .rd2_o(rd2_o),
    .imm_o(imm_o), .valid_o(valid_o), .stall_req_o(stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int addr);
    if (addr == 0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_regwrite_i && int'(wb_writereg_i) == addr) return wb_result_i;
`endif
    return m_regs[addr];
  endfunction

  function automatic logic m_hazard();
    int dst;
    dst = int'(m_instr[20:16]);
    return m_valid && (int'(m_instr[31:26]) == 'h23) && (dst != 0) && valid_i &&
           (dst == int'(instr_i[25:21]) || dst == int'(instr_i[20:16]));
  endfunction

  // One clock: check the hazard flag, advance the model, then check the registered outputs.
  task automatic step(input string tag);
    logic        hz;
    logic [31:0] n_rd1, n_rd2, n_imm, raw;
    int          op;
    #1;
    hz = m_hazard();
    chk({tag, ".stall_req"}, 32'(stall_req_o), 32'(hz));
    n_rd1 = m_read(int'(instr_i[25:21]));
    n_rd2 = m_read(int'(instr_i[20:16]));
    op    = int'(instr_i[31:26]);
    raw   = 32'(instr_i[15:0]);
    if (op >= 'h0C && op <= 'h0E) n_imm = raw;
    else if (raw >= 32'h8000)     n_imm = raw - 32'h10000;
    else                          n_imm = raw;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      {m_instr, m_pc, m_rd1, m_rd2, m_imm, m_valid} = '0;
    end else begin
      if (flush_i || (!stall_i && hz)) begin
        {m_instr, m_pc, m_rd1, m_rd2, m_imm, m_valid} = '0;
      end else if (!stall_i) begin
        m_instr = instr_i; m_pc = pc_plus4_i; m_rd1 = n_rd1; m_rd2 = n_rd2;
        m_imm = n_imm; m_valid = valid_i;
      end
      if (wb_regwrite_i && wb_writereg_i != 5'd0) m_regs[int'(wb_writereg_i)] = wb_result_i;
    end
    @(posedge clk);
    #1;
    chk({tag, ".instr_o"},    instr_o,    m_instr);
    chk({tag, ".pc_plus4_o"}, pc_plus4_o, m_pc);
    chk({tag, ".rd1_o"},      rd1_o,      m_rd1);
    chk({tag, ".rd2_o"},      rd2_o,      m_rd2);
    chk({tag, ".imm_o"},      imm_o,      m_imm);
    chk({tag, ".valid_o"},    32'(valid_o), 32'(m_valid));
  endtask

  task automatic idle();
    reset = 1'b0; instr_i = 32'h0; valid_i = 1'b0; pc_plus4_i = $urandom;
    wb_regwrite_i = 1'b0; wb_writereg_i = 5'd0; wb_result_i = 32'h0;
    stall_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_regwrite_i = 1'b1; wb_writereg_i = r; wb_result_i = d;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [7];
    ops = '{6'h00, 6'h23, 6'h23, 6'h0C, 6'h0D, 6'h0E, 6'h08};
    return i_type(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  16'($urandom));
  endfunction

  initial begin
    logic [31:0] frozen;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'hX;
    {m_instr, m_pc, m_rd1, m_rd2, m_imm, m_valid} = '0;

    // Reset state
    idle(); reset = 1'b1; valid_i = 1'b1; instr_i = 32'hFFFF_FFFF; flush_i = 1'b1;
    step("reset");
    chk("reset.valid_o", 32'(valid_o), 32'h0);
    chk("reset.instr_o", instr_o, 32'h0);

    // Write R5 then read it back via decode
    idle(); wb(5'd5, 32'hDEAD_BEEF); step("wr_r5");
    idle(); instr_i = r_type(5'd5, 5'd0, 5'd8); valid_i = 1'b1; step("rd_r5");
    chk("rd_r5.exact_rd1", rd1_o, 32'hDEAD_BEEF);
    chk("rd_r5.exact_rd2", rd2_o, 32'h0);

    // Same-cycle write and read of R7
    idle(); wb(5'd7, 32'hAAAA_5555); step("wr_r7_old");
    idle(); wb(5'd7, 32'h1234_5678); instr_i = r_type(5'd7, 5'd0, 5'd1); valid_i = 1'b1;
    step("same_cycle_r7");
`ifdef DECODE_WB_BYPASS_EN
    chk("same_cycle_r7.exact", rd1_o, 32'h1234_5678);
`else
    chk("same_cycle_r7.exact", rd1_o, 32'hAAAA_5555);
`endif
    idle(); instr_i = r_type(5'd7, 5'd0, 5'd1); valid_i = 1'b1; step("next_cycle_r7");
    chk("next_cycle_r7.exact", rd1_o, 32'h1234_5678);

    // Load-use hazard: lw $8,0($9) followed by add $10,$8,$11
    idle(); instr_i = i_type(6'h23, 5'd9, 5'd8, 16'h0); valid_i = 1'b1; step("lw");
    idle(); instr_i = r_type(5'd8, 5'd11, 5'd10); valid_i = 1'b1;
    #1 chk("lu.stall_req_high", 32'(stall_req_o), 32'h1);
    step("lu_bubble");
    chk("lu_bubble.valid_o", 32'(valid_o), 32'h0);
    chk("lu_bubble.stall_req_low", 32'(stall_req_o), 32'h0);
    step("lu_capture");
    chk("lu_capture.instr_o", instr_o, r_type(5'd8, 5'd11, 5'd10));

    // Immediate extension
    idle(); instr_i = i_type(6'h0D, 5'd0, 5'd2, 16'h8000); valid_i = 1'b1; step("ori");
    chk("ori.exact_imm", imm_o, 32'h0000_8000);
    idle(); instr_i = i_type(6'h08, 5'd0, 5'd2, 16'h8000); valid_i = 1'b1; step("addi");
    chk("addi.exact_imm", imm_o, 32'hFFFF_8000);

    // External stall for 3 cycles, then flush together with stall
    idle(); frozen = r_type(5'd5, 5'd7, 5'd3); instr_i = frozen; valid_i = 1'b1; step("pre_stall");
    for (int i = 0; i < 3; i++) begin
      idle(); stall_i = 1'b1; instr_i = rand_instr(); valid_i = 1'b1; step("stall_hold");
      chk("stall_hold.exact_instr", instr_o, frozen);
    end
    idle(); stall_i = 1'b1; flush_i = 1'b1; instr_i = rand_instr(); valid_i = 1'b1; step("stall_flush");
    chk("stall_flush.valid_o", 32'(valid_o), 32'h0);

    // Reset in the middle of a stall, with a pending write
    idle(); wb(5'd3, 32'h1); step("wr_r3");
    idle(); stall_i = 1'b1; step("stall_before_reset");
    idle(); stall_i = 1'b1; reset = 1'b1; wb(5'd4, 32'h5555_AAAA); step("reset_in_stall");
    chk("reset_in_stall.valid_o", 32'(valid_o), 32'h0);
    idle(); instr_i = r_type(5'd3, 5'd4, 5'd1); valid_i = 1'b1; step("rd_r3");
    chk("rd_r3.exact_rd1", rd1_o, 32'h0);
    idle(); wb(5'd0, 32'hFFFF_FFFF); step("wr_r0");
    idle(); instr_i = r_type(5'd0, 5'd0, 5'd1); valid_i = 1'b1; step("rd_r0");
    chk("rd_r0.exact_rd1", rd1_o, 32'h0);

    // Random traffic biased toward register collisions and hazards
    for (int n = 0; n < 400; n++) begin
      idle();
      instr_i       = rand_instr();
      valid_i       = ($urandom_range(0, 3) != 0);
      wb_regwrite_i = $urandom_range(0, 1) == 1;
      wb_writereg_i = 5'($urandom_range(0, 7));
      wb_result_i   = $urandom;
      stall_i       = ($urandom_range(0, 7) == 0);
      flush_i       = ($urandom_range(0, 15) == 0);
      reset         = ($urandom_range(0, 63) == 0);
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
